boton_pulsos: RTL
=================

# boton_pulsos

Press classifier sitting directly downstream of the button debouncer. It takes the debounced, active-high button level (1 = pressed) and turns each press into exactly one event:
- a one-cycle short-press pulse on release, or
- a one-cycle long-press pulse once the hold time is reached, plus a held level for as long as the button stays down.

The pet/energy control FSM consumes these pulses instead of raw levels.

## Interface
- LONG_CYCLES, 100_000_000: consecutive pressed cycles that make a long press (2 s at 50 MHz); must be > MIN_CYCLES.
- MIN_CYCLES, 1: minimum consecutive pressed cycles for a release to count as a short press; must be ≥ 1.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- boton_in  input  1  debounced button level, already synchronous to clk; 1 = pressed.
- pulso_corto  output  1  one-cycle pulse: short press completed.
- pulso_largo  output  1  one-cycle pulse: long-press threshold reached.
- sostenido  output  1  high while a press that already produced pulso_largo is still held.

## Operation
- Internal hold counter `cnt`, width $clog2(LONG_CYCLES+1), unsigned. It never exceeds LONG_CYCLES, so no wrap is possible.
- All outputs are registered. The FSM has four states:
  - ARM: entered on reset. Waits for boton_in = 0, then goes to IDLE. A button held through reset release produces no event.
  - IDLE: on boton_in = 1, go to PRESSED with cnt <= 1. Otherwise cnt <= 0.
  - PRESSED:
    - If boton_in = 0: go to IDLE and clear cnt. Assert pulso_corto only if cnt ≥ MIN_CYCLES; otherwise discard silently.
    - Else, if cnt + 1 = LONG_CYCLES: set cnt <= LONG_CYCLES, assert pulso_largo, set sostenido <= 1, go to LONG_HELD.
    - Else: cnt <= cnt + 1.
  - LONG_HELD: while boton_in = 1, hold state with sostenido = 1. On boton_in = 0, go to IDLE with sostenido <= 0 and cnt <= 0. No pulso_corto is produced.
- pulso_corto and pulso_largo are never high in the same cycle. Each press yields at most one pulse.
- Reset asserted (reset = 0) at any time: state ARM, cnt = 0, pulso_corto = pulso_largo = sostenido = 0, all immediately and asynchronously. Any press in progress is discarded.

## Timing
- Let edge k be the first rising edge that samples boton_in = 1 from IDLE.
- pulso_largo is high for exactly one cycle after edge k+LONG_CYCLES-1, provided every edge k..k+LONG_CYCLES-1 sampled 1. sostenido rises on that same edge.
- Release first sampled at edge r (PRESSED):
  - pulso_corto is high for exactly one cycle after edge r when r-k ≥ MIN_CYCLES.
  - There is no pulse when r-k < MIN_CYCLES.
- Release sampled at edge r in LONG_HELD: sostenido falls after edge r.
- A new press can be recognised on the edge after returning to IDLE, i.e. edge r+1.
- Exact boundary: a press of LONG_CYCLES-1 cycles gives pulso_corto; a press of LONG_CYCLES cycles gives pulso_largo only.
- Latency from the boton_in change to the output is one clock.

## Test plan
Use LONG_CYCLES = 10, MIN_CYCLES = 2.
- Reset (0 for 3 cycles) with boton_in = 0, then release reset: all outputs 0, and no pulse for 20 idle cycles.
- Press 5 cycles, then release: pulso_corto = 1 for exactly 1 cycle, one clock after the release edge. pulso_largo and sostenido stay 0.
- Press 1 cycle, then release: no pulse. Press 9 cycles: pulso_corto. Press 10 cycles: pulso_largo only, with no pulso_corto on release.
- Hold 25 cycles: pulso_largo = 1 once, one cycle after the 10th pressed edge. sostenido = 1 from then until one cycle after release, then 0.
- Hold boton_in = 1 through reset release for 15 cycles, then release and press 4 cycles: no event during the first hold, and pulso_corto for the second press.
- Assert reset at pressed cycle 7 of a hold: outputs 0 immediately, FSM enters ARM. With the button still held after reset release, no pulso_largo is produced.

Source files
------------

// File: rtl/boton_pulsos.sv
// boton_pulsos: classifies each debounced button press as a short press
// (one-cycle pulse on release) or a long press (one-cycle pulse at the hold
// threshold, plus a level that stays high until the button is let go).
module boton_pulsos #(
  parameter int LONG_CYCLES = 100_000_000,
  parameter int MIN_CYCLES  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_in,
  output logic pulso_corto,
  output logic pulso_largo,
  output logic sostenido
);

  localparam int CW = $clog2(LONG_CYCLES + 1);

  localparam logic [CW-1:0] LONG_C = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LAST_C = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_CYCLES);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  localparam logic [1:0] ARM       = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] PRESSED   = 2'd2;
  localparam logic [1:0] LONG_HELD = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          corto_nxt;
  logic          largo_nxt;
  logic          sost_nxt;

  // Next-state logic: decides transitions, counter update and output values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    corto_nxt = 1'b0;
    largo_nxt = 1'b0;
    sost_nxt  = sostenido;
    case (state)
      ARM: begin
        cnt_nxt  = '0;
        sost_nxt = 1'b0;
        if (!boton_in) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        sost_nxt = 1'b0;
        if (boton_in) begin
          state_nxt = PRESSED;
          cnt_nxt   = ONE_C;
        end else begin
          cnt_nxt = '0;
        end
      end
      PRESSED: begin
        if (!boton_in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          corto_nxt = (cnt >= MIN_C);
        end else if (cnt == LAST_C) begin
          state_nxt = LONG_HELD;
          cnt_nxt   = LONG_C;
          largo_nxt = 1'b1;
          sost_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE_C;
        end
      end
      LONG_HELD: begin
        if (!boton_in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sost_nxt  = 1'b0;
        end else begin
          sost_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ARM;
        cnt_nxt   = '0;
        sost_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset discards any press in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARM;
      cnt         <= '0;
      pulso_corto <= 1'b0;
      pulso_largo <= 1'b0;
      sostenido   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pulso_corto <= corto_nxt;
      pulso_largo <= largo_nxt;
      sostenido   <= sost_nxt;
    end
  end

endmodule
